video_decode: RTL and testbench
===============================

VIDEO_DECODE -- requirements
Module: video_decode

Interface
REQ-001 Parameter FG_RGB, 24'hFFFFFF, colour output for VIDEO=1.
REQ-002 Parameter SCORE_RGB, 24'hFFFFFF, colour output for SCORE=1 with VIDEO=0.
REQ-003 Parameter BG_RGB, 24'h000000, colour output when neither VIDEO nor SCORE is 1.
REQ-004 Parameter LOCK_FRAMES, 2, number of consecutive matching frames required to assert LOCKED (range 1..15).
REQ-005 CLK_VIDEO  in  1  the single clock; all logic runs on its rising edge.
REQ-006 RESET_N  in  1  reset, asynchronous, active-low.
REQ-007 VIDEO, SCORE  in  1 each  game monochrome playfield and score pixels, synchronous to CLK_VIDEO.
REQ-008 HSYNC, VSYNC  in  1 each  active-high sync pulses.
REQ-009 HBLANK, VBLANK  in  1 each  active-high blanking.
REQ-010 RGB  out  24  decoded pixel colour.
REQ-011 DE  out  1  data enable, high for active pixels.
REQ-012 HS, VS  out  1 each  registered copies of HSYNC and VSYNC.
REQ-013 X, Y  out  9 each  active pixel and line coordinates.
REQ-014 LINE_LEN  out  10  last measured line length in clocks.
REQ-015 FRAME_LINES  out  10  last measured frame length in lines.
REQ-016 LOCKED  out  1  timing is stable.

Function
REQ-017 The block registers every input once and derives rising edges from that registered copy; inputs are synchronous to CLK_VIDEO, so no synchronizer is present.
REQ-018 RGB, DE, HS, VS, X and Y have a latency of exactly 1 clock from the sampled inputs.
REQ-019 DE = !HBLANK & !VBLANK; RGB = BG_RGB when DE=0; when DE=1, priority is VIDEO (FG_RGB), then SCORE (SCORE_RGB), then BG_RGB.
REQ-020 X clears to 0 when HBLANK=1, increments by 1 on each DE cycle and saturates at 511; the first active pixel of each line outputs X=0.
REQ-021 An internal line counter clears while VBLANK=1 and increments on each HBLANK rising edge while VBLANK=0; Y equals this counter during DE, saturating at 511; the first active line outputs Y=0.
REQ-022 A 10-bit clock counter resets to 1 on each HSYNC rising edge and otherwise increments, saturating at 1023; at each HSYNC rising edge its prior value is loaded into LINE_LEN.
REQ-023 A 10-bit line counter increments on each HSYNC rising edge and saturates at 1023; on each VSYNC rising edge it loads into FRAME_LINES and clears.
REQ-024 A mismatch flag sets when a loaded LINE_LEN differs from the previous LINE_LEN; the flag is evaluated, then cleared, at each VSYNC rising edge.
REQ-025 Lock FSM states are SEARCH, TRACK and LOCK, with a 4-bit match count.
REQ-026 SEARCH -> TRACK on the first VSYNC rising edge; match count = 0.
REQ-027 TRACK, on a VSYNC rising edge: if FRAME_LINES is unchanged and the mismatch flag is clear, match count +1; on reaching LOCK_FRAMES, go to LOCK; otherwise match count = 0 and the FSM stays in TRACK.
REQ-028 LOCK, on a VSYNC rising edge with a mismatch: go to TRACK with match count = 0.
REQ-029 LOCKED = 1 only in LOCK; it is registered and changes 1 clock after the deciding edge.
REQ-030 Watchdog: if the clock counter saturates at 1023 (no HSYNC), the FSM goes to SEARCH from any state, LOCKED = 0 and the match count clears.
REQ-031 If HSYNC and VSYNC rise in the same cycle, the HSYNC line count increment is applied before the FRAME_LINES load.
REQ-032 The first LINE_LEN and FRAME_LINES values loaded after reset are never compared against the reset value 0.

Reset
REQ-033 While RESET_N=0: RGB=BG_RGB, DE=0, HS=0, VS=0, X=0, Y=0, LINE_LEN=0, FRAME_LINES=0, LOCKED=0, FSM=SEARCH, and all counters and flags are 0.
REQ-034 Reset asserted mid-frame takes effect asynchronously; after release the block restarts in SEARCH and needs at least LOCK_FRAMES+1 full frames to relock.

Verification
REQ-035 Stimulus: 454-clock lines, HSYNC 32 clocks, HBLANK 80 clocks, 262 lines per frame, VBLANK 22 lines -> LINE_LEN=454, FRAME_LINES=262, LOCKED rises 1 clock after the 3rd VSYNC rising edge (LOCK_FRAMES=2).
REQ-036 VIDEO=1 and SCORE=1 at the 1st active pixel of the 1st active line -> next clock RGB=FG_RGB, DE=1, X=0, Y=0; the last active pixel of the line gives X=373.
REQ-037 Once locked, one line is shortened to 453 clocks -> LOCKED falls 1 clock after the next VSYNC rising edge and returns after 2 further clean frames.
REQ-038 Once locked, HSYNC is held low -> the clock counter saturates at 1023, the FSM goes to SEARCH and LOCKED=0.
REQ-039 RESET_N pulsed low mid-line -> all outputs immediately take their reset values; the relock sequence repeats REQ-035.
REQ-040 HSYNC and VSYNC rising in the same cycle -> FRAME_LINES includes that line.

Source files
------------

// File: rtl/video_decode.sv
// Decodes a monochrome arcade video stream into RGB with active-area coordinates,
// and measures line/frame timing to report when the incoming sync is stable.
module video_decode #(
  parameter logic [23:0] FG_RGB      = 24'hFFFFFF,
  parameter logic [23:0] SCORE_RGB   = 24'hFFFFFF,
  parameter logic [23:0] BG_RGB      = 24'h000000,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        CLK_VIDEO,
  input  logic        RESET_N,
  input  logic        VIDEO,
  input  logic        SCORE,
  input  logic        HSYNC,
  input  logic        VSYNC,
  input  logic        HBLANK,
  input  logic        VBLANK,
  output logic [23:0] RGB,
  output logic        DE,
  output logic        HS,
  output logic        VS,
  output logic [8:0]  X,
  output logic [8:0]  Y,
  output logic [9:0]  LINE_LEN,
  output logic [9:0]  FRAME_LINES,
  output logic        LOCKED
);

  localparam logic [3:0] LockCount = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {StSearch, StTrack, StLock} lock_state_e;

  lock_state_e state_q, state_d;
  logic        hsync_q, vsync_q, hblank_q;
  logic [23:0] rgb_q, rgb_d;
  logic        de_q;
  logic [8:0]  x_q, y_q, x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic [9:0]  clk_cnt_q, clk_cnt_d, line_cnt_q, line_cnt_d, line_inc;
  logic [9:0]  line_len_q, line_len_d, frame_lines_q, frame_lines_d;
  logic        len_valid_q, mismatch_q, mismatch_d, ref_valid_q, ref_valid_d;
  logic [3:0]  match_q, match_d;
  logic        locked_q;

  logic hs_rise, vs_rise, hb_rise, de_in, wdog;
  logic len_diff, mismatch_now, frame_diff;

  always_comb begin
    hs_rise = HSYNC & ~hsync_q;
    vs_rise = VSYNC & ~vsync_q;
    hb_rise = HBLANK & ~hblank_q;
    de_in   = ~HBLANK & ~VBLANK;
    wdog    = (clk_cnt_q == 10'h3FF);

    rgb_d = BG_RGB;
    if (de_in) begin
      if (VIDEO) begin
        rgb_d = FG_RGB;
      end else if (SCORE) begin
        rgb_d = SCORE_RGB;
      end
    end

    x_cnt_d = x_cnt_q;
    if (HBLANK) begin
      x_cnt_d = '0;
    end else if (de_in && x_cnt_q != 9'h1FF) begin
      x_cnt_d = x_cnt_q + 9'd1;
    end

    y_cnt_d = y_cnt_q;
    if (VBLANK) begin
      y_cnt_d = '0;
    end else if (hb_rise && y_cnt_q != 9'h1FF) begin
      y_cnt_d = y_cnt_q + 9'd1;
    end

    clk_cnt_d  = clk_cnt_q;
    line_len_d = line_len_q;
    if (hs_rise) begin
      clk_cnt_d  = 10'd1;
      line_len_d = clk_cnt_q;
    end else if (!wdog) begin
      clk_cnt_d = clk_cnt_q + 10'd1;
    end

    // The first length after reset is a partial line and has nothing valid to compare to.
    len_diff     = hs_rise & len_valid_q & (clk_cnt_q != line_len_q);
    mismatch_now = mismatch_q | len_diff;

    // A coincident HSYNC edge belongs to the frame being closed by VSYNC.
    line_inc = line_cnt_q;
    if (hs_rise && line_cnt_q != 10'h3FF) begin
      line_inc = line_cnt_q + 10'd1;
    end
    frame_diff = ref_valid_q & (line_inc != frame_lines_q);

    line_cnt_d    = vs_rise ? 10'd0 : line_inc;
    frame_lines_d = vs_rise ? line_inc : frame_lines_q;
    mismatch_d    = vs_rise ? 1'b0 : mismatch_now;
  end

  always_comb begin
    state_d     = state_q;
    match_d     = match_q;
    ref_valid_d = ref_valid_q;
    if (wdog) begin
      state_d     = StSearch;
      match_d     = '0;
      ref_valid_d = 1'b0;
    end else if (vs_rise) begin
      unique case (state_q)
        StSearch: begin
          state_d = StTrack;
          match_d = '0;
        end
        StTrack: begin
          ref_valid_d = 1'b1;
          if (!mismatch_now && !frame_diff) begin
            match_d = match_q + 4'd1;
            if (match_d == LockCount) begin
              state_d = StLock;
            end
          end else begin
            match_d = '0;
          end
        end
        StLock: begin
          ref_valid_d = 1'b1;
          if (mismatch_now || frame_diff) begin
            state_d = StTrack;
            match_d = '0;
          end
        end
        default: state_d = StSearch;
      endcase
    end
  end

  always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
    if (!RESET_N) begin
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      hblank_q      <= 1'b0;
      rgb_q         <= BG_RGB;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      x_cnt_q       <= '0;
      y_cnt_q       <= '0;
      clk_cnt_q     <= '0;
      line_cnt_q    <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      len_valid_q   <= 1'b0;
      mismatch_q    <= 1'b0;
      ref_valid_q   <= 1'b0;
      match_q       <= '0;
      state_q       <= StSearch;
      locked_q      <= 1'b0;
    end else begin
      hsync_q       <= HSYNC;
      vsync_q       <= VSYNC;
      hblank_q      <= HBLANK;
      rgb_q         <= rgb_d;
      de_q          <= de_in;
      x_q           <= de_in ? x_cnt_q : 9'd0;
      y_q           <= de_in ? y_cnt_q : 9'd0;
      x_cnt_q       <= x_cnt_d;
      y_cnt_q       <= y_cnt_d;
      clk_cnt_q     <= clk_cnt_d;
      line_cnt_q    <= line_cnt_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      len_valid_q   <= len_valid_q | hs_rise;
      mismatch_q    <= mismatch_d;
      ref_valid_q   <= ref_valid_d;
      match_q       <= match_d;
      state_q       <= state_d;
      locked_q      <= (state_d == StLock);
    end
  end

  assign RGB         = rgb_q;
  assign DE          = de_q;
  assign HS          = hsync_q;
  assign VS          = vsync_q;
  assign X           = x_q;
  assign Y           = y_q;
  assign LINE_LEN    = line_len_q;
  assign FRAME_LINES = frame_lines_q;
  assign LOCKED      = locked_q;

endmodule

// File: tb/tb_video_decode.sv
// Bench for video_decode: randomized pixels over generated sync timing, checked each
// cycle against a behavioural model, plus literal expectations at key points.
module tb_video_decode;

  localparam logic [23:0] FG = 24'hFF8000;
  localparam logic [23:0] SC = 24'h00FF40;
  localparam logic [23:0] BG = 24'h101020;
  localparam int LOCK_FRAMES = 2;
  localparam int LINE_CLKS   = 454;
  localparam int HBL_CLKS    = 80;
  localparam int HS_OFS      = 64;
  localparam int HS_CLKS     = 32;
  localparam int FRAME_LN    = 6;
  localparam int ACT_LN      = 4;
  localparam int VS_LINE     = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic video = 1'b0, score = 1'b0, hsync = 1'b0, vsync = 1'b0;
  logic hblank = 1'b1, vblank = 1'b1;
  logic [23:0] rgb;
  logic de, hs, vs, locked;
  logic [8:0] x, y;
  logic [9:0] line_len, frame_lines;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  video_decode #(
    .FG_RGB(FG), .SCORE_RGB(SC), .BG_RGB(BG), .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .CLK_VIDEO(clk), .RESET_N(rst_n), .VIDEO(video), .SCORE(score),
    .HSYNC(hsync), .VSYNC(vsync), .HBLANK(hblank), .VBLANK(vblank),
    .RGB(rgb), .DE(de), .HS(hs), .VS(vs), .X(x), .Y(y),
    .LINE_LEN(line_len), .FRAME_LINES(frame_lines), .LOCKED(locked)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [23:0] e_rgb;
  bit e_de, e_hs, e_vs, e_locked;
  int e_x, e_y, e_len, e_frame;
  int m_x, m_y, m_clk, m_lines, m_run;
  bit m_len_ok, m_bad, m_ref_ok, m_synced, m_locked, m_phs, m_pvs, m_phb;

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic m_reset();
    e_rgb = BG; e_de = 0; e_hs = 0; e_vs = 0; e_locked = 0;
    e_x = 0; e_y = 0; e_len = 0; e_frame = 0;
    m_x = 0; m_y = 0; m_clk = 0; m_lines = 0; m_run = 0;
    m_len_ok = 0; m_bad = 0; m_ref_ok = 0; m_synced = 0; m_locked = 0;
    m_phs = 0; m_pvs = 0; m_phb = 0;
  endtask

  task automatic m_step();
    bit hs_rise, vs_rise, hb_rise, act, wd, bad_now, clean;
    int lines_new;
    hs_rise = hsync && !m_phs;
    vs_rise = vsync && !m_pvs;
    hb_rise = hblank && !m_phb;
    act = !hblank && !vblank;
    e_de = act; e_hs = hsync; e_vs = vsync;
    e_rgb = !act ? BG : video ? FG : score ? SC : BG;
    e_x = act ? m_x : 0;
    e_y = act ? m_y : 0;
    if (hblank) m_x = 0; else if (act) m_x = sat(m_x + 1, 511);
    if (vblank) m_y = 0; else if (hb_rise) m_y = sat(m_y + 1, 511);
    wd = (m_clk == 1023);
    bad_now = m_bad;
    clean = 0;
    lines_new = hs_rise ? sat(m_lines + 1, 1023) : m_lines;
    if (hs_rise) begin
      if (m_len_ok && m_clk != e_len) bad_now = 1;
      e_len = m_clk; m_len_ok = 1; m_clk = 1;
    end else begin
      m_clk = sat(m_clk + 1, 1023);
    end
    if (vs_rise) begin
      clean = !bad_now && (!m_ref_ok || lines_new == e_frame);
      e_frame = lines_new; m_lines = 0; m_bad = 0;
    end else begin
      m_lines = lines_new; m_bad = bad_now;
    end
    if (wd) begin
      m_synced = 0; m_run = 0; m_locked = 0; m_ref_ok = 0;
    end else if (vs_rise) begin
      if (!m_synced) begin
        m_synced = 1; m_run = 0;
      end else begin
        m_ref_ok = 1;
        if (m_locked) begin
          if (!clean) begin m_locked = 0; m_run = 0; end
        end else begin
          m_run = clean ? m_run + 1 : 0;
          if (m_run == LOCK_FRAMES) m_locked = 1;
        end
      end
    end
    e_locked = m_locked;
    m_phs = hsync; m_pvs = vsync; m_phb = hblank;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset(); else m_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("rgb", rgb, e_rgb);
      chk("de", de, e_de);
      chk("hs", hs, e_hs);
      chk("vs", vs, e_vs);
      chk("x", x, e_x);
      chk("y", y, e_y);
      chk("line_len", line_len, e_len);
      chk("frame_lines", frame_lines, e_frame);
      chk("locked", locked, e_locked);
    end
  end

  // ---------------- stimulus ----------------
  task automatic check_reset_vals(input string tag);
    chk({tag, "_rgb"}, rgb, BG);
    chk({tag, "_de"}, de, 0);
    chk({tag, "_hs"}, hs, 0);
    chk({tag, "_vs"}, vs, 0);
    chk({tag, "_x"}, x, 0);
    chk({tag, "_y"}, y, 0);
    chk({tag, "_line_len"}, line_len, 0);
    chk({tag, "_frame_lines"}, frame_lines, 0);
    chk({tag, "_locked"}, locked, 0);
  endtask

  task automatic check_locked_timing(input string tag, input int lock_exp);
    chk({tag, "_line_len"}, line_len, LINE_CLKS);
    chk({tag, "_frame_lines"}, frame_lines, FRAME_LN);
    chk({tag, "_locked"}, locked, lock_exp);
  endtask

  // exp_before/exp_after: LOCKED just before / just after the VSYNC rise is sampled (-1 skips).
  task automatic run_frame(input bit coinc, input int short_line, input int exp_before,
                           input int exp_after, input int rst_line, input int rst_clk);
    int len, vs_clk, hs_start;
    for (int l = 0; l < FRAME_LN; l++) begin
      len = (l == short_line) ? LINE_CLKS - 1 : LINE_CLKS;
      hs_start = len - HS_OFS;
      vs_clk = coinc ? hs_start : 0;
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        if (l == VS_LINE && c == vs_clk && exp_before >= 0)
          chk("locked_before_vs", locked, exp_before);
        if (l == VS_LINE && c == vs_clk + 1 && exp_after >= 0)
          chk("locked_after_vs", locked, exp_after);
        if (l == 0 && c == 1) begin
          chk("first_px_rgb", rgb, FG);
          chk("first_px_de", de, 1);
          chk("first_px_x", x, 0);
          chk("first_px_y", y, 0);
        end
        if (l == 0 && c == len - HBL_CLKS) begin
          chk("last_px_x", x, 373);
          chk("last_px_de", de, 1);
        end
        if (l == 0 && c == len - HBL_CLKS + 1) begin
          chk("blank_de", de, 0);
          chk("blank_x", x, 0);
          chk("blank_rgb", rgb, BG);
        end
        if (l == rst_line && c == rst_clk + 3) rst_n = 1'b1;
        hblank = (c >= len - HBL_CLKS);
        hsync  = (c >= hs_start) && (c < hs_start + HS_CLKS);
        vblank = (l >= ACT_LN);
        vsync  = coinc ? ((l == VS_LINE && c >= hs_start) || (l == VS_LINE + 1 && c < hs_start))
                       : (l == VS_LINE);
        video  = 1'($urandom_range(1, 0));
        score  = 1'($urandom_range(1, 0));
        if (l == 0 && c == 0) begin
          video = 1'b1;
          score = 1'b1;
        end
        if (l == rst_line && c == rst_clk) begin
          #2 rst_n = 1'b0;
          #1 check_reset_vals("async_rst");
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      hblank = 1'b1; vblank = 1'b1; hsync = 1'b0; vsync = 1'b0;
      video = 1'($urandom_range(1, 0));
      score = 1'($urandom_range(1, 0));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst_n = 1'b1;

    // Initial acquisition: lock right after the third VSYNC rise.
    run_frame(0, -1, 0, 0, -1, -1);
    run_frame(0, -1, 0, 0, -1, -1);
    run_frame(0, -1, 0, 1, -1, -1);
    check_locked_timing("lock1", 1);

    // One short line drops lock, two clean frames restore it.
    run_frame(0, 1, 1, 0, -1, -1);
    run_frame(0, -1, 0, 0, -1, -1);
    run_frame(0, -1, 0, 1, -1, -1);
    check_locked_timing("relock_short", 1);

    // VSYNC coincident with HSYNC: the phase shift costs one frame, then 6 lines counted.
    run_frame(1, -1, 1, 0, -1, -1);
    run_frame(1, -1, 0, 0, -1, -1);
    chk("coinc_frame_lines", frame_lines, FRAME_LN);
    run_frame(1, -1, 0, 0, -1, -1);
    run_frame(1, -1, 0, 1, -1, -1);
    check_locked_timing("coinc_lock", 1);

    // HSYNC missing long enough to saturate the clock counter.
    idle(1100);
    chk("wdog_locked", locked, 0);
    chk("wdog_line_len", line_len, LINE_CLKS);
    run_frame(0, -1, 0, 0, -1, -1);
    run_frame(0, -1, 0, 0, -1, -1);
    run_frame(0, -1, 0, 1, -1, -1);
    check_locked_timing("relock_wdog", 1);

    // Asynchronous reset in the middle of line 1, then reacquire.
    run_frame(0, -1, 0, 0, 1, 200);
    run_frame(0, -1, 0, 0, -1, -1);
    run_frame(0, -1, 0, 1, -1, -1);
    check_locked_timing("relock_rst", 1);

    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
